// File: rtl/rf_seq_pkg.sv
// ---------------------------------------------------------------------------
// rf_seq_pkg
// Shared definitions for the register-file execute/write-back sequencer:
//   - default data/address widths of the 8x16 register file
//   - ALU opcode encoding (op_e)
//   - sequencer FSM state encoding (state_e)
// No ports; imported by alu_16 and rf_alu_sequencer.
// ---------------------------------------------------------------------------
package rf_seq_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;
  localparam int OP_W       = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_MOV = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/alu_16.sv
// ---------------------------------------------------------------------------
// alu_16
// Purely combinational ALU used by rf_alu_sequencer.
// Ports:
//   op    in  3       opcode (rf_seq_pkg::op_e encoding)
//   a     in  DATA_W  operand A
//   b     in  DATA_W  operand B
//   y     out DATA_W  result, modulo 2^DATA_W
//   carry out 1       ADD: carry out; SUB: borrow (a<b unsigned);
//                     SHL: bit shifted out (a[MSB]); all others 0
// ---------------------------------------------------------------------------
module alu_16
  import rf_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              carry
);

  // One extra bit on both the sum and the difference: the top bit is the
  // carry for ADD and, because the subtraction wraps, the borrow for SUB.
  logic [DATA_W:0] sum_ext;
  logic [DATA_W:0] diff_ext;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  always_comb begin
    y     = '0;
    carry = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        y     = sum_ext[DATA_W-1:0];
        carry = sum_ext[DATA_W];
      end
      OP_SUB: begin
        y     = diff_ext[DATA_W-1:0];
        carry = diff_ext[DATA_W];
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_NOT: y = ~a;
      OP_SHL: begin
        y     = {a[DATA_W-2:0], 1'b0};
        carry = a[DATA_W-1];
      end
      OP_MOV: y = b;
      default: begin
        y     = '0;
        carry = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rf_alu_sequencer.sv
// ---------------------------------------------------------------------------
// rf_alu_sequencer
// Four-cycle execute/write-back controller in front of an 8x16 register
// file. One register-to-register instruction is accepted per handshake:
//   IDLE (accept, present read addresses) -> READ (capture operands)
//   -> EXEC (compute result) -> WB (write-back pulse) -> IDLE
// The sequencer is the only writer of the register file.
//
// Optional build macro: ALU_FLAGS_EN adds flag_z / flag_c / flag_n.
//
// Ports:
//   clk           in   1       rising-edge clock
//   reset         in   1       asynchronous, active-low reset
//   instr_valid   in   1       instruction fields valid
//   instr_ready   out  1       high only in IDLE
//   op            in   3       opcode (rf_seq_pkg::op_e)
//   rd_sel        in   ADDR_W  destination register
//   rs_a, rs_b    in   ADDR_W  source registers
//   rf_rd_addr_a  out  ADDR_W  register file read address A
//   rf_rd_addr_b  out  ADDR_W  register file read address B
//   rf_d_out_a    in   DATA_W  register file read data A (combinational)
//   rf_d_out_b    in   DATA_W  register file read data B (combinational)
//   rf_wr         out  1       write enable, one-cycle pulse in WB
//   rf_wr_addr    out  ADDR_W  write address
//   rf_d_in       out  DATA_W  write data
//   result        out  DATA_W  last computed result, held until next EXEC
//   done          out  1       one-cycle pulse, coincident with rf_wr
//   flag_z/c/n    out  1       (ALU_FLAGS_EN only) zero / carry / negative
// ---------------------------------------------------------------------------
module rf_alu_sequencer
  import rf_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   op,
  input  logic [ADDR_W-1:0] rd_sel,
  input  logic [ADDR_W-1:0] rs_a,
  input  logic [ADDR_W-1:0] rs_b,
  output logic [ADDR_W-1:0] rf_rd_addr_a,
  output logic [ADDR_W-1:0] rf_rd_addr_b,
  input  logic [DATA_W-1:0] rf_d_out_a,
  input  logic [DATA_W-1:0] rf_d_out_b,
  output logic              rf_wr,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_d_in,
  output logic [DATA_W-1:0] result,
  output logic              done
`ifdef ALU_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_n
`endif
);

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] rd_addr_a_q, rd_addr_a_d;
  logic [ADDR_W-1:0] rd_addr_b_q, rd_addr_b_d;
  logic              rf_wr_q, rf_wr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] d_in_q, d_in_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              done_q, done_d;
`ifdef ALU_FLAGS_EN
  logic              flag_z_q, flag_z_d;
  logic              flag_c_q, flag_c_d;
  logic              flag_n_q, flag_n_d;
`endif

  // -------------------------------------------------------------------------
  // ALU on the captured operands
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] alu_y;
  logic              alu_carry;

  alu_16 #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op    (op_q),
    .a     (opa_q),
    .b     (opb_q),
    .y     (alu_y),
    .carry (alu_carry)
  );

`ifndef ALU_FLAGS_EN
  // Without the flag registers the carry output has no consumer.
  logic unused_alu_carry;
  assign unused_alu_carry = alu_carry;
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    ready_d     = ready_q;
    rd_addr_a_d = rd_addr_a_q;
    rd_addr_b_d = rd_addr_b_q;
    wr_addr_d   = wr_addr_q;
    d_in_d      = d_in_q;
    result_d    = result_q;
    // Strobes default low so they only ever last one cycle.
    rf_wr_d     = 1'b0;
    done_d      = 1'b0;
`ifdef ALU_FLAGS_EN
    flag_z_d    = flag_z_q;
    flag_c_d    = flag_c_q;
    flag_n_d    = flag_n_q;
`endif

    case (state_q)
      S_IDLE: begin
        // ready_q is high throughout IDLE; fields are sampled only here.
        if (instr_valid && ready_q) begin
          op_d        = op;
          rd_d        = rd_sel;
          rd_addr_a_d = rs_a;
          rd_addr_b_d = rs_b;
          ready_d     = 1'b0;
          state_d     = S_READ;
        end
      end

      S_READ: begin
        // Read addresses were registered at accept, so the file's
        // combinational read data is stable for this whole cycle.
        opa_d   = rf_d_out_a;
        opb_d   = rf_d_out_b;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        // Result and write-port outputs are loaded together so that
        // rf_wr, rf_d_in and done all appear as registers during WB.
        result_d  = alu_y;
        d_in_d    = alu_y;
        wr_addr_d = rd_q;
        rf_wr_d   = 1'b1;
        done_d    = 1'b1;
`ifdef ALU_FLAGS_EN
        flag_z_d  = (alu_y == '0);
        flag_c_d  = alu_carry;
        flag_n_d  = alu_y[DATA_W-1];
`endif
        state_d   = S_EXEC == state_q ? S_WB : S_IDLE;
      end

      S_WB: begin
        // The write lands on the edge that leaves WB; raising ready here
        // means the next accept cannot precede it.
        ready_d = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers; reset aborts any instruction in flight.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      ready_q     <= 1'b1;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      rf_wr_q     <= 1'b0;
      wr_addr_q   <= '0;
      d_in_q      <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
`ifdef ALU_FLAGS_EN
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_n_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      ready_q     <= ready_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      rf_wr_q     <= rf_wr_d;
      wr_addr_q   <= wr_addr_d;
      d_in_q      <= d_in_d;
      result_q    <= result_d;
      done_q      <= done_d;
`ifdef ALU_FLAGS_EN
      flag_z_q    <= flag_z_d;
      flag_c_q    <= flag_c_d;
      flag_n_q    <= flag_n_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign instr_ready  = ready_q;
  assign rf_rd_addr_a = rd_addr_a_q;
  assign rf_rd_addr_b = rd_addr_b_q;
  assign rf_wr        = rf_wr_q;
  assign rf_wr_addr   = wr_addr_q;
  assign rf_d_in      = d_in_q;
  assign result       = result_q;
  assign done         = done_q;
`ifdef ALU_FLAGS_EN
  assign flag_z       = flag_z_q;
  assign flag_c       = flag_c_q;
  assign flag_n       = flag_n_q;
`endif

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rf_alu_sequencer
// Bench for rf_alu_sequencer with a behavioural 8x16 register file.
// Build with +define+ALU_FLAGS_EN to also check the flag outputs.
// ---------------------------------------------------------------------------
module tb_rf_alu_sequencer;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    op;
  logic [AW-1:0] rd_sel, rs_a, rs_b;
  logic [AW-1:0] rf_rd_addr_a, rf_rd_addr_b;
  logic [DW-1:0] rf_d_out_a, rf_d_out_b;
  logic          rf_wr;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_d_in;
  logic [DW-1:0] result;
  logic          done;
`ifdef ALU_FLAGS_EN
  logic          flag_z, flag_c, flag_n;
`endif

  rf_alu_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .op           (op),
    .rd_sel       (rd_sel),
    .rs_a         (rs_a),
    .rs_b         (rs_b),
    .rf_rd_addr_a (rf_rd_addr_a),
    .rf_rd_addr_b (rf_rd_addr_b),
    .rf_d_out_a   (rf_d_out_a),
    .rf_d_out_b   (rf_d_out_b),
    .rf_wr        (rf_wr),
    .rf_wr_addr   (rf_wr_addr),
    .rf_d_in      (rf_d_in),
    .result       (result),
    .done         (done)
`ifdef ALU_FLAGS_EN
    ,
    .flag_z       (flag_z),
    .flag_c       (flag_c),
    .flag_n       (flag_n)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural register file: combinational read, write on rising edge.
  logic [DW-1:0] regs [8];
  assign rf_d_out_a = regs[rf_rd_addr_a];
  assign rf_d_out_b = regs[rf_rd_addr_b];
  always @(posedge clk) if (rf_wr) regs[rf_wr_addr] <= rf_d_in;

  // Reference view of the register contents.
  int unsigned model [8];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wr_pulses   = 0;
  int done_pulses = 0;
  int acc_cycle   = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rf_wr) wr_pulses <= wr_pulses + 1;
    if (done)  done_pulses <= done_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int idx, input int unsigned val);
    regs[idx]  = val[DW-1:0];
    model[idx] = val & 32'hFFFF;
  endtask

  // Returns {carry, y[15:0]} computed with plain integer arithmetic.
  function automatic logic [16:0] ref_alu(input logic [2:0] opc, input int unsigned a,
                                          input int unsigned b);
    int unsigned r;
    bit          c;
    r = 0;
    c = 0;
    case (opc)
      3'd0: begin r = a + b; c = (r > 65535); end
      3'd1: begin r = a - b; c = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: begin r = a * 2; c = (a >= 32768); end
      default: r = b;
    endcase
    r = r & 32'hFFFF;
    return {c, r[15:0]};
  endfunction

  // Issue one instruction from a negedge and follow it through write-back.
  // garble: drive random fields with valid high while busy (must be ignored).
  // keep:   leave instr_valid high at the end for a back-to-back follow-up.
  task automatic run_instr(input logic [2:0] opc, input int rd, input int a, input int b,
                           input bit garble, input bit keep);
    logic [16:0] exp;
    int          w;
    instr_valid = 1'b1;
    op     = opc;
    rd_sel = AW'(rd);
    rs_a   = AW'(a);
    rs_b   = AW'(b);
    w = 0;
    while (!instr_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!instr_ready) begin
      check("ready_timeout", 32'(instr_ready), 32'd1);
      instr_valid = 1'b0;
      return;
    end
    exp = ref_alu(opc, model[a], model[b]);
    @(posedge clk);
    acc_cycle = cyc;
    @(negedge clk);
    check("read_ready", 32'(instr_ready), 32'd0);
    check("read_addr_a", 32'(rf_rd_addr_a), 32'(a));
    check("read_addr_b", 32'(rf_rd_addr_b), 32'(b));
    check("read_wr", 32'(rf_wr), 32'd0);
    if (garble) begin
      op     = 3'($urandom);
      rd_sel = AW'($urandom);
      rs_a   = AW'($urandom);
      rs_b   = AW'($urandom);
    end else begin
      instr_valid = 1'b0;
    end
    @(negedge clk);
    check("exec_ready", 32'(instr_ready), 32'd0);
    check("exec_wr", 32'(rf_wr), 32'd0);
    check("exec_done", 32'(done), 32'd0);
    @(negedge clk);
    check("wb_ready", 32'(instr_ready), 32'd0);
    check("wb_wr", 32'(rf_wr), 32'd1);
    check("wb_done", 32'(done), 32'd1);
    check("wb_addr", 32'(rf_wr_addr), 32'(rd));
    check("wb_data", 32'(rf_d_in), 32'(exp[15:0]));
    check("wb_result", 32'(result), 32'(exp[15:0]));
`ifdef ALU_FLAGS_EN
    check("flag_z", 32'(flag_z), 32'(exp[15:0] == 16'h0));
    check("flag_c", 32'(flag_c), 32'(exp[16]));
    check("flag_n", 32'(flag_n), 32'(exp[15]));
`endif
    @(negedge clk);
    model[rd] = 32'(exp[15:0]);
    check("idle_ready", 32'(instr_ready), 32'd1);
    check("idle_wr", 32'(rf_wr), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_result", 32'(result), 32'(exp[15:0]));
    check("rf_value", 32'(regs[rd]), model[rd]);
    $display("op=%0d rd=%0d a=%0d b=%0d -> y=%04h c=%0d", opc, rd, a, b, exp[15:0], exp[16]);
    if (!keep) instr_valid = 1'b0;
  endtask

  initial begin
    int p_wr, p_done, acc1;

    reset       = 1'b0;
    instr_valid = 1'b0;
    op          = '0;
    rd_sel      = '0;
    rs_a        = '0;
    rs_b        = '0;
    for (int i = 0; i < 8; i++) preload(i, 0);

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_wr", 32'(rf_wr), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_a", 32'(rf_rd_addr_a), 32'd0);
    check("rst_rd_b", 32'(rf_rd_addr_b), 32'd0);
    check("rst_wr_addr", 32'(rf_wr_addr), 32'd0);
    check("rst_d_in", 32'(rf_d_in), 32'd0);
    check("rst_result", 32'(result), 32'd0);
`ifdef ALU_FLAGS_EN
    check("rst_flags", 32'({flag_z, flag_c, flag_n}), 32'd0);
`endif
    reset = 1'b1;

    // Idle for 20 cycles: nothing happens
    p_wr   = wr_pulses;
    p_done = done_pulses;
    repeat (20) @(negedge clk);
    check("idle20_wr", 32'(wr_pulses - p_wr), 32'd0);
    check("idle20_done", 32'(done_pulses - p_done), 32'd0);
    check("idle20_ready", 32'(instr_ready), 32'd1);

    // Directed: ADD, SUB to negative, SHL with carry, ADD wrap to zero
    preload(2, 16'h0005);
    preload(3, 16'h0003);
    run_instr(3'd0, 1, 2, 3, 1'b0, 1'b0);
    preload(4, 16'h0000);
    preload(5, 16'h0001);
    run_instr(3'd1, 6, 4, 5, 1'b0, 1'b0);
    preload(0, 16'h8001);
    run_instr(3'd6, 0, 0, 0, 1'b0, 1'b0);
    check("shl_r0", 32'(regs[0]), 32'h0002);
    preload(7, 16'hFFFF);
    run_instr(3'd0, 2, 7, 5, 1'b0, 1'b0);
    check("wrap_r2", 32'(regs[2]), 32'h0000);

    // Back-to-back: second instruction reads the first's destination
    preload(2, 16'h0005);
    preload(3, 16'h0007);
    run_instr(3'd0, 4, 2, 3, 1'b1, 1'b1);
    acc1 = acc_cycle;
    run_instr(3'd1, 5, 4, 2, 1'b0, 1'b0);
    check("accept_gap", 32'(acc_cycle - acc1), 32'd4);
    check("hazard_r5", 32'(regs[5]), 32'h0007);

    // Randomised instructions against the reference model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) preload($urandom_range(0, 7), $urandom_range(0, 65535));
      run_instr(3'($urandom), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7), 1'($urandom), 1'($urandom));
    end
    instr_valid = 1'b0;
    @(negedge clk);

    // Reset during EXEC of MOV rd=3: the write must be lost
    preload(3, 16'h1234);
    preload(6, 16'hBEEF);
    p_wr = wr_pulses;
    instr_valid = 1'b1;
    op     = 3'd7;
    rd_sel = 3'd3;
    rs_a   = 3'd1;
    rs_b   = 3'd6;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_wr", 32'(rf_wr), 32'd0);
    check("abort_ready", 32'(instr_ready), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_pulses", 32'(wr_pulses - p_wr), 32'd0);
    check("abort_r3", 32'(regs[3]), model[3]);
    check("abort_result", 32'(result), 32'd0);
    check("abort_d_in", 32'(rf_d_in), 32'd0);
    check("abort_wr_addr", 32'(rf_wr_addr), 32'd0);
    check("abort_rd_a", 32'(rf_rd_addr_a), 32'd0);
    check("abort_rd_b", 32'(rf_rd_addr_b), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ready2", 32'(instr_ready), 32'd1);
    $display("reset during EXEC: r3=%04h", regs[3]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
